uart_imem_loader: RTL and testbench

UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

---
 rtl/uart_imem_loader.sv | 204 ++++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader.sv
// UART boot loader: receives an A5/count/data frame and writes words to imem.
// Optional checksum byte after the data: define LOADER_CHECKSUM_EN.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_BITS  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] F_IDLE  = 3'd0;
    localparam logic [2:0] F_COUNT = 3'd1;
    localparam logic [2:0] F_DATA  = 3'd2;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] F_CHECK = 3'd3;
`endif
    localparam logic [2:0] F_DONE  = 3'd4;

    logic              rx_s1, rx_s2, rx_s3;
    logic [1:0]        rx_st;
    logic [CW-1:0]     cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              byte_valid;
    logic              frame_err;

    logic [2:0]        st;
    logic [8:0]        nwords;
    logic [8:0]        wcnt;
    logic [1:0]        bcnt;
    logic [31:0]       wbuf;
    logic [ADDR_W-1:0] widx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // Two-flop synchronizer plus one extra stage for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // 8N1 receiver: start re-check at half bit, then one sample per bit centre
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_st      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_st <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        rx_st   <= rx_s2 ? RX_IDLE : RX_BITS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_st <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        rx_st      <= RX_IDLE;
                        byte_valid <= rx_s2;
                        frame_err  <= !rx_s2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Frame FSM: sync byte, word count, little-endian word assembly, writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= F_IDLE;
            nwords     <= '0;
            wcnt       <= '0;
            bcnt       <= '0;
            wbuf       <= '0;
            widx       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (frame_err) begin
                err        <= 1'b1;
                core_reset <= 1'b1;
                done       <= 1'b0;
                st         <= F_IDLE;
            end else if (byte_valid) begin
                case (st)
                    F_IDLE, F_DONE: begin
                        if (shreg == 8'hA5) begin
                            core_reset <= 1'b1;
                            done       <= 1'b0;
                            err        <= 1'b0;
                            widx       <= '0;
                            st         <= F_COUNT;
                        end
                    end
                    F_COUNT: begin
                        nwords <= (shreg == 8'h00) ? 9'd256 : {1'b0, shreg};
                        wcnt   <= '0;
                        bcnt   <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum   <= '0;
`endif
                        st     <= F_DATA;
                    end
                    F_DATA: begin
                        wbuf <= {shreg, wbuf[31:8]};
                        bcnt <= bcnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ shreg;
`endif
                        if (bcnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= widx;
                            imem_wdata <= {shreg, wbuf[31:8]};
                            widx       <= widx + 1'b1;
                            wcnt       <= wcnt + 1'b1;
                            if (wcnt == nwords - 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                st <= F_CHECK;
`else
                                st         <= F_DONE;
                                done       <= 1'b1;
                                core_reset <= 1'b0;
`endif
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    F_CHECK: begin
                        if (shreg == csum) begin
                            st         <= F_DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            err <= 1'b1;
                            st  <= F_IDLE;
                        end
                    end
`endif
                    default: st <= F_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed + randomized bench for uart_imem_loader (CLKS_PER_BIT=4, ADDR_W=8).
// Expected writes come from a byte-stream model computed in the bench.
module tb_uart_imem_loader;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [39:0] got_w[$];
    logic [39:0] exp_w[$];

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Capture every write strobe cycle away from the active edge
    always @(negedge clk) begin
        if (imem_we) got_w.push_back({imem_addr, imem_wdata});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(CPB);
        end
        rx = stop;
        cyc(CPB);
        rx = 1'b1;
        cyc(CPB + 2);
    endtask

    task automatic cmp_writes(input string tag);
        int n;
        chk({tag, "_nwrites"}, 64'(got_w.size()), 64'(exp_w.size()));
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_write"}, 64'(got_w[i]), 64'(exp_w[i]));
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_core_reset"}, 64'(core_reset), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    // Model: n words of random bytes, word i = b0 + b1*2^8 + b2*2^16 + b3*2^24
    task automatic rand_load(input string tag, input int n, input bit garbage);
        logic [7:0] b;
        logic [7:0] x;
        logic [31:0] w;
        got_w.delete();
        exp_w.delete();
        x = 8'h00;
        if (garbage) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b, 1'b1);
        end
        send_byte(8'hA5, 1'b1);
        chk({tag, "_core_reset_at_a5"}, 64'(core_reset), 64'd1);
        chk({tag, "_done_at_a5"}, 64'(done), 64'd0);
        send_byte(8'(n % 256), 1'b1);
        for (int i = 0; i < n; i++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++) begin
                b = 8'($urandom_range(0, 255));
                x = x ^ b;
                w = w + (32'(b) << (8 * k));
                send_byte(b, 1'b1);
            end
            exp_w.push_back({8'(i % 256), w});
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, 1'b1);
`endif
        cyc(4);
        cmp_writes(tag);
        chk_done(tag);
    endtask

    initial begin
        rx = 1'b1;
        reset = 1'b0;
        cyc(2);
        chk("rst_we", 64'(imem_we), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset = 1'b1;
        cyc(3);

        // Basic load
        got_w.delete();
        exp_w.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hB3, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h31, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h82, 1'b1);
        send_byte(8'h62, 1'b1);
        send_byte(8'h40, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hB3 ^ 8'h31 ^ 8'h33 ^ 8'h82 ^ 8'h62 ^ 8'h40, 1'b1);
`endif
        cyc(4);
        exp_w.push_back({8'd0, 32'h003100B3});
        exp_w.push_back({8'd1, 32'h40628233});
        cmp_writes("basic");
        chk_done("basic");

        // Garbage skip
        got_w.delete();
        exp_w.delete();
        send_byte(8'h11, 1'b1);
        send_byte(8'hFF, 1'b1);
        chk("garbage_done_kept", 64'(done), 64'd1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h93, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h41, 1'b1);
        send_byte(8'h06, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h93 ^ 8'h41 ^ 8'h06, 1'b1);
`endif
        cyc(4);
        exp_w.push_back({8'd0, 32'h06410093});
        cmp_writes("garbage");
        chk_done("garbage");

        // Framing error on 3rd data byte
        got_w.delete();
        exp_w.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b1);
        cyc(4);
        chk("ferr_err", 64'(err), 64'd1);
        chk("ferr_core_reset", 64'(core_reset), 64'd1);
        chk("ferr_done", 64'(done), 64'd0);
        cmp_writes("ferr");
        rand_load("after_ferr", 2, 1'b0);

        // Randomized loads
        for (int t = 0; t < 3; t++)
            rand_load("rand", int'($urandom_range(1, 5)), 1'b1);

        // Reset mid-word
        got_w.delete();
        exp_w.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        rx = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(2);
        chk("mid_we", 64'(imem_we), 64'd0);
        chk("mid_addr", 64'(imem_addr), 64'd0);
        chk("mid_wdata", 64'(imem_wdata), 64'd0);
        chk("mid_core_reset", 64'(core_reset), 64'd1);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_err", 64'(err), 64'd0);
        rx = 1'b1;
        reset = 1'b1;
        cyc(3 * CPB * 10);
        cmp_writes("mid");
        chk("mid_core_reset_after", 64'(core_reset), 64'd1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum good then bad
        got_w.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hC0, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h2F, 1'b1);
        cyc(4);
        chk("csum_good_done", 64'(done), 64'd1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hC0, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        cyc(4);
        chk("csum_bad_err", 64'(err), 64'd1);
        chk("csum_bad_done", 64'(done), 64'd0);
        chk("csum_bad_core_reset", 64'(core_reset), 64'd1);
`endif

        // Reload with count 0 meaning 256 words
        rand_load("pre256", 1, 1'b0);
        rand_load("cnt0", 256, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
